// File: rtl/schedule_responder.sv
// Responder end of the Schedule phase interface: runs NOP/SEED/WARMUP/GENERATE phases on a
// 32-bit Galois LFSR and streams 2-bit bases. Define SCHED_RESP_PHASE_CHECK_EN to flag illegal phases on err.
module schedule_responder #(
    parameter int WARMUP_CYCLES = 16,
    parameter int NUM_SITES     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_phase,
    input  logic [7:0] seed_ID,
    output logic [1:0] base,
    output logic       base_valid,
    input  logic       base_ready,
    output logic       done,
    output logic       busy,
    output logic       err
);
    localparam int MAX_CNT = (WARMUP_CYCLES > NUM_SITES) ? WARMUP_CYCLES : NUM_SITES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0]      LFSR_RESET = 32'h0000_0001;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GEN_LAST   = CNT_W'(NUM_SITES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NOP  = 3'd1,
        S_SEED = 3'd2,
        S_WARM = 3'd3,
        S_GEN  = 3'd4,
        S_ILL  = 3'd5
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [7:0]       seed_q, seed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             base_valid_q, base_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SCHED_RESP_PHASE_CHECK_EN
    logic             err_q, err_d;
`endif

    // Next-state logic: phase decode on acceptance, per-phase LFSR stepping and completion.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        seed_d       = seed_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        base_valid_d = base_valid_q;
        done_d       = 1'b0;
        busy_d       = busy_q;
`ifdef SCHED_RESP_PHASE_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    seed_d      = seed_ID;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    case (cmd_phase)
                        3'b000:  state_d = S_NOP;
                        3'b001:  state_d = S_SEED;
                        3'b010:  state_d = S_WARM;
                        3'b011:  state_d = S_GEN;
                        default: state_d = S_ILL;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NOP: begin
                done_d      = 1'b1;
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_SEED: begin
                // Low byte A5 keeps the loaded state non-zero for any seed.
                lfsr_d      = {seed_q, ~seed_q, seed_q, 8'hA5};
                done_d      = 1'b1;
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_WARM: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == WARM_LAST) begin
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = S_WARM;
                end
            end
            S_GEN: begin
                if (!base_valid_q) begin
                    base_valid_d = 1'b1;
                end else if (base_ready) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == GEN_LAST) begin
                        base_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                        cmd_ready_d  = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        state_d = S_GEN;
                    end
                end else begin
                    state_d = S_GEN;
                end
            end
            S_ILL: begin
`ifdef SCHED_RESP_PHASE_CHECK_EN
                err_d       = 1'b1;
`else
                done_d      = 1'b1;
`endif
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                cmd_ready_d  = 1'b1;
                base_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_RESET;
            seed_q       <= 8'h00;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            base_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SCHED_RESP_PHASE_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            seed_q       <= seed_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            base_valid_q <= base_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef SCHED_RESP_PHASE_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign base_valid = base_valid_q;
    assign base       = lfsr_q[1:0];
    assign done       = done_q;
    assign busy       = busy_q;
`ifdef SCHED_RESP_PHASE_CHECK_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_schedule_responder.sv
// Directed bench for schedule_responder: phase timing, LFSR model and a base scoreboard.
module tb_schedule_responder;
    localparam int WARM  = 16;
    localparam int SITES = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_phase;
    logic [7:0] seed_ID;
    logic [1:0] base;
    logic       base_valid;
    logic       base_ready;
    logic       done;
    logic       busy;
    logic       err;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  sb_q[$];
    logic [31:0] mdl;
    int          gen_dn;
    int          gen_stab;
    int          hs;
    int          edges;

    schedule_responder #(.WARMUP_CYCLES(WARM), .NUM_SITES(SITES)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_phase(cmd_phase), .seed_ID(seed_ID), .base(base), .base_valid(base_valid),
        .base_ready(base_ready), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] s;
        s = {1'b0, v[31:1]};
        if (v[0]) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a command and return 1ns after its acceptance edge.
    task automatic issue(input logic [2:0] ph, input logic [7:0] sd);
        int k;
        k = 0;
        cmd_phase = ph;
        seed_ID   = sd;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("cmd_ready_before_accept", cmd_ready, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_expected(input int n);
        logic [31:0] m;
        m = mdl;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(m[1:0]);
            m = model_step(m);
        end
    endtask

    // Drive base_ready, score every handshake, stop after 'target' handshakes.
    task automatic gen_run(input int target, input bit rnd, input bit chk_first, output int n_hs);
        int         cyc;
        bit         stalled;
        bit         hs_now;
        logic [1:0] held;
        logic [1:0] exp_b;
        n_hs = 0; cyc = 0; stalled = 1'b0; held = 2'b00;
        gen_dn = 0; gen_stab = 0;
        while (n_hs < target && cyc < 4000) begin
            base_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled && base_valid === 1'b1 && base !== held) gen_stab++;
            if (done === 1'b1) gen_dn++;
            stalled = (base_valid === 1'b1) && !base_ready;
            held    = base;
            hs_now  = (base_valid === 1'b1) && base_ready;
            if (hs_now) begin
                exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 2'bxx;
                check("base_scoreboard", base, exp_b);
                mdl = model_step(mdl);
                n_hs++;
            end
            @(posedge clk); #1;
            if (chk_first && hs_now && n_hs == 1) check("lfsr_after_first_hs", dut.lfsr_q, 32'h805F_8051);
            cyc++;
        end
        base_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_phase = 3'b000; seed_ID = 8'h00; base_ready = 1'b0;
        mdl = 32'h0000_0001;
        #23 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 32'd1);
        check("rst_done", done, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_base_valid", base_valid, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_lfsr", dut.lfsr_q, 32'h0000_0001);

        // NOP: busy from acceptance, done for exactly one cycle after T+1
        issue(3'b000, 8'h00);
        check("nop_busy", busy, 32'd1);
        check("nop_ready_low", cmd_ready, 32'd0);
        @(posedge clk); #1;
        check("nop_done", done, 32'd1);
        check("nop_ready_back", cmd_ready, 32'd1);
        check("nop_busy_clr", busy, 32'd0);
        @(posedge clk); #1;
        check("nop_done_single", done, 32'd0);

        // SEED 0x00
        issue(3'b001, 8'h00);
        check("seed_lfsr_held", dut.lfsr_q, 32'h0000_0001);
        @(posedge clk); #1;
        check("seed_done", done, 32'd1);
        check("seed_lfsr", dut.lfsr_q, 32'h00FF_00A5);
        mdl = 32'h00FF_00A5;

        // GENERATE with random backpressure
        push_expected(SITES);
        issue(3'b011, 8'h00);
        check("gen_bv_low_at_T", base_valid, 32'd0);
        check("gen_no_done_T", done, 32'd0);
        @(posedge clk); #1;
        check("gen_bv_rise", base_valid, 32'd1);
        check("gen_first_base", base, 32'd1);
        gen_run(SITES, 1'b1, 1'b1, hs);
        check("gen_hs_count", hs, SITES);
        check("gen_done_last", done, 32'd1);
        check("gen_bv_fall", base_valid, 32'd0);
        check("gen_early_done", gen_dn, 32'd0);
        check("gen_base_stable", gen_stab, 32'd0);
        check("gen_sb_empty", sb_q.size(), 32'd0);
        check("gen_lfsr_end", dut.lfsr_q, mdl);

        // WARMUP back to back with the GENERATE completion
        issue(3'b010, 8'h00);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            check("warm_busy", busy, 32'd1);
            @(posedge clk); #1;
            edges++;
        end
        for (int i = 0; i < WARM; i++) mdl = model_step(mdl);
        check("warm_latency", edges, WARM);
        check("warm_lfsr", dut.lfsr_q, mdl);
        @(posedge clk); #1;
        check("warm_done_single", done, 32'd0);

        // Illegal phase 101
        issue(3'b101, 8'h3C);
        check("ill_busy", busy, 32'd1);
        @(posedge clk); #1;
`ifdef SCHED_RESP_PHASE_CHECK_EN
        check("ill_err", err, 32'd1);
        check("ill_no_done", done, 32'd0);
`else
        check("ill_done", done, 32'd1);
        check("ill_err_tied", err, 32'd0);
`endif
        check("ill_lfsr", dut.lfsr_q, mdl);
        check("ill_ready", cmd_ready, 32'd1);

        // Reset during GENERATE after 10 handshakes
        push_expected(SITES);
        issue(3'b011, 8'h00);
        gen_run(10, 1'b0, 1'b0, hs);
        check("abort_hs10", hs, 32'd10);
        base_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("abort_cmd_ready", cmd_ready, 32'd1);
        check("abort_bv", base_valid, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_busy", busy, 32'd0);
        check("abort_lfsr", dut.lfsr_q, 32'h0000_0001);
        @(posedge clk); #1;
        check("abort_done_hold", done, 32'd0);
        #3 reset = 1'b0;
        base_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_err_clr", err, 32'd0);
        check("abort_no_done", done, 32'd0);

        // Full GENERATE from the reset LFSR value
        sb_q.delete();
        mdl = 32'h0000_0001;
        push_expected(SITES);
        issue(3'b011, 8'h00);
        gen_run(SITES, 1'b0, 1'b0, hs);
        check("regen_hs_count", hs, SITES);
        check("regen_done", done, 32'd1);
        check("regen_bv_fall", base_valid, 32'd0);
        check("regen_early_done", gen_dn, 32'd0);
        check("regen_lfsr", dut.lfsr_q, mdl);
        @(posedge clk); #1;
        check("regen_done_single", done, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
